// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer.
//   - cause encodings reported on the cause output
//   - PC increment and the lowest PC bit kept across an absolute jump
//   - next-PC source selector used inside pc_seq_ctrl
package pc_pkg;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_EXC   = 2'd1;
    localparam logic [1:0] CAUSE_ALIGN = 2'd2;

    localparam int PC_INC      = 4;
    localparam int JUMP_HI_BIT = 28;

    typedef enum logic [2:0] {
        SEQ,
        BR,
        J,
        JR,
        ERET,
        EXC
    } npc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack used for jr target prediction.
// Only instantiated when PC_RAS_EN is defined.
//
// Ports:
//   clk, reset : clock, synchronous active-high reset (empties the stack)
//   push       : write push_val on top (overwrites the oldest entry when full)
//   pop        : remove the top entry and compare it to cmp_val
//   push_val   : return address to push
//   cmp_val    : architectural jr target
//   miss       : combinational, high during a pop that finds the stack empty
//                or whose top entry differs from cmp_val
//
// A simultaneous pop and push pops first, so the pushed value replaces
// the popped top entry.
import pc_pkg::*;

module pc_ras #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_val,
    input  logic [WIDTH-1:0] cmp_val,
    output logic             miss
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] stack_q [RAS_DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    top_idx;
    logic             wr_en;
    logic [PW-1:0]    wr_idx;

    // ptr_q is the next write slot, so the top entry sits one below it
    // (modulo the depth, which makes the buffer circular).
    assign top_idx = ptr_q - PW'(1);

    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        miss   = 1'b0;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (pop) begin
            if (cnt_q == '0) begin
                miss = 1'b1;
            end else begin
                miss  = (stack_q[top_idx] != cmp_val);
                ptr_d = top_idx;
                cnt_d = cnt_q - CW'(1);
            end
        end
        if (push) begin
            wr_en  = 1'b1;
            wr_idx = ptr_d;
            ptr_d  = ptr_d + PW'(1);
            // Count saturates; once full, the write wraps onto the oldest entry.
            if (cnt_d != CW'(RAS_DEPTH)) begin
                cnt_d = cnt_d + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            stack_q[wr_idx] <= push_val;
        end
    end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Program-counter sequencer for the single-cycle MIPS datapath.
// Chooses the next fetch address from sequential, branch, jump, jump-register,
// exception and exception-return sources; keeps EPC, cause and an
// in-exception flag.
//
// Optional feature: macro PC_RAS_EN adds a return-address stack (pc_ras)
// that predicts jr targets and flags mispredictions on ras_miss. Without
// it ras_miss is tied 0.
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   stall       : hold all state unless an exception is accepted
//   pcsrc, jump : conditional branch / absolute jump requests
//   jr, rs_val  : jump to register value
//   link        : JAL/JALR (return-address push when PC_RAS_EN)
//   exc, eret   : exception request / return from exception
//   instr       : instruction bits [25:0] (branch offset, jump index)
//   pc, pc_plus4: current fetch address and pc+4
//   epc, cause, in_exc : exception state
//   ras_miss    : jr target disagreed with RAS prediction (combinational)
import pc_pkg::*;

module pc_seq_ctrl #(
    parameter int          WIDTH     = 32,
    parameter logic [63:0] RESET_VEC = 64'h0000_0000,
    parameter logic [63:0] EXC_VEC   = 64'h8000_0180,
    parameter int          RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             pcsrc,
    input  logic             jump,
    input  logic             jr,
    input  logic             link,
    input  logic             exc,
    input  logic             eret,
    input  logic [25:0]      instr,
    input  logic [WIDTH-1:0] rs_val,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] epc,
    output logic [1:0]       cause,
    output logic             in_exc,
    output logic             ras_miss
);

    localparam logic [WIDTH-1:0] RST_PC = RESET_VEC[WIDTH-1:0];
    localparam logic [WIDTH-1:0] EXC_PC = EXC_VEC[WIDTH-1:0];

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [1:0]       cause_q, cause_d;
    logic             in_exc_q, in_exc_d;

    logic [WIDTH-1:0] br_off;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] j_target;
    logic             align_err;
    logic             exc_take;
    logic             hold;
    npc_sel_e         sel;

    assign pc_plus4  = pc_q + WIDTH'(PC_INC);
    assign br_off    = {{(WIDTH-18){instr[15]}}, instr[15:0], 2'b00};
    assign br_target = pc_plus4 + br_off;
    assign j_target  = {pc_plus4[WIDTH-1:JUMP_HI_BIT], instr, 2'b00};

    assign align_err = jr && (rs_val[1:0] != 2'b00);
    // Nested exceptions are dropped; the handler must eret first.
    assign exc_take  = (align_err || exc) && !in_exc_q;

    always_comb begin
        sel      = SEQ;
        hold     = 1'b0;
        epc_d    = epc_q;
        cause_d  = cause_q;
        in_exc_d = in_exc_q;
        if (exc_take) begin
            // An accepted exception is taken even under stall.
            sel      = EXC;
            epc_d    = pc_q;
            cause_d  = align_err ? CAUSE_ALIGN : CAUSE_EXC;
            in_exc_d = 1'b1;
        end else if (stall) begin
            hold = 1'b1;
        end else if (eret && in_exc_q) begin
            sel      = ERET;
            in_exc_d = 1'b0;
        end else if (jr) begin
            sel = JR;
        end else if (jump) begin
            sel = J;
        end else if (pcsrc) begin
            sel = BR;
        end

        unique case (sel)
            BR:      pc_d = br_target;
            J:       pc_d = j_target;
            JR:      pc_d = rs_val;
            ERET:    pc_d = epc_q;
            EXC:     pc_d = EXC_PC;
            default: pc_d = pc_plus4;
        endcase
        if (hold) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RST_PC;
            epc_q    <= '0;
            cause_q  <= CAUSE_NONE;
            in_exc_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            epc_q    <= epc_d;
            cause_q  <= cause_d;
            in_exc_q <= in_exc_d;
        end
    end

    assign pc     = pc_q;
    assign epc    = epc_q;
    assign cause  = cause_q;
    assign in_exc = in_exc_q;

`ifdef PC_RAS_EN
    logic ras_push;
    logic ras_pop;

    // The stack only moves on cycles that actually retire the instruction.
    assign ras_push = link && !stall && !exc_take;
    assign ras_pop  = (sel == JR);

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .reset    (reset),
        .push     (ras_push),
        .pop      (ras_pop),
        .push_val (pc_plus4),
        .cmp_val  (rs_val),
        .miss     (ras_miss)
    );
`else
    logic link_unused;
    assign link_unused = link;
    assign ras_miss    = 1'b0;
`endif

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
Next-generation program-counter sequencer for the single-cycle MIPS datapath, parametrised in address width and vectors. Selects the next PC from sequential, branch, jump, jump-register, exception and exception-return sources, and honours a stall input. Holds an EPC/cause pair and an in-exception flag. Sits where the fetch address is produced, feeding instruction memory and the control unit.

Parameters:
WIDTH, 32, PC/address width; legal values 32 or 64.
RESET_VEC, 0x0000_0000, PC value loaded on reset, zero-extended to WIDTH.
EXC_VEC, 0x8000_0180, exception handler address, zero-extended to WIDTH.
RAS_DEPTH, 4, return-address stack entries; used only with PC_RAS_EN; power of two, at least 2.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-high.
stall  in  1  hold the PC this cycle.
pcsrc  in  1  take the conditional branch.
jump  in  1  J/JAL absolute jump.
jr  in  1  jump to rs_val.
link  in  1  current instruction is JAL or JALR (RAS push).
exc  in  1  synchronous exception request.
eret  in  1  return from exception.
instr  in  26  instruction bits [25:0].
rs_val  in  WIDTH  register operand used by jr.
pc  out  WIDTH  current fetch address.
pc_plus4  out  WIDTH  pc+4, combinational; link value for JAL.
epc  out  WIDTH  PC saved at the last accepted exception.
cause  out  2  0=none, 1=external exc, 2=misaligned jr target.
in_exc  out  1  handler active.
ras_miss  out  1  RAS prediction mismatch (PC_RAS_EN only; tied 0 otherwise).

Behaviour:
- Reset: pc=RESET_VEC, epc=0, cause=0, in_exc=0, RAS empty. Reset overrides every other input.
- Arithmetic, all WIDTH bits, modulo 2^WIDTH:
  - pc_plus4 = pc+4.
  - branch target = pc_plus4 + (sign-extended instr[15:0] << 2).
  - jump target = {pc_plus4[WIDTH-1:28], instr[25:0], 2'b00}.
- Next-PC priority, evaluated every non-reset cycle:
  - misaligned jr, i.e. jr=1 and rs_val[1:0]!=0: treated as an exception with cause=2.
  - exc: exception with cause=1.
  - eret.
  - jr.
  - jump.
  - pcsrc.
  - sequential.
- Exception acceptance (exc or misaligned jr) requires in_exc=0. On acceptance: pc<=EXC_VEC, epc<=pc, cause<=1 or 2, in_exc<=1. This applies even when stall=1.
- Exception while in_exc=1: ignored. The remaining sources are still evaluated.
- eret with in_exc=1: pc<=epc, in_exc<=0; cause is retained. eret with in_exc=0 is a no-op and the PC advances by the remaining priority.
- stall=1 with no accepted exception: pc, epc, cause, in_exc and RAS all hold. Branch, jump, jr and eret are discarded.
- Single-cycle latency: the selected target appears on pc the cycle after the request.
- Simultaneous pcsrc and jump: jump wins.

Optional Feature:
Macro PC_RAS_EN.
- Defined:
  - Circular RAS of RAS_DEPTH entries with a pointer.
  - A non-stalled cycle with link=1 pushes pc_plus4.
  - A non-stalled jr pops the top entry and compares it to rs_val.
  - ras_miss pulses for one cycle when the stack is empty or the values differ.
  - Push when full overwrites the oldest entry (wrap-around).
  - Pop when empty leaves the pointer unchanged.
  - rs_val always remains the architectural target.
  - An accepted exception leaves the RAS untouched.
- Undefined: no RAS storage; ras_miss is tied 0.

Decomposition:
- Shared package pc_pkg holds:
  - cause encodings CAUSE_NONE, CAUSE_EXC, CAUSE_ALIGN.
  - constants PC_INC=4, JUMP_HI_BIT=28.
  - next-PC select enum: SEQ, BR, J, JR, ERET, EXC.
- One sub-module, pc_ras, holds the stack, pointer and compare; it is instantiated only under PC_RAS_EN.

Test Plan:
- Reset with RESET_VEC=0x400 held for 2 cycles, then 3 free cycles -> pc 0x400, 0x404, 0x408, 0x40C; epc=0, cause=0.
- pc=0x1000, pcsrc=1, instr[15:0]=0xFFFE -> next pc=0x0FFC. Same with instr=0x0000010 and jump=1 -> 0x0000_0040.
- pc=0x2000 with stall=1 and pcsrc=1 for 3 cycles -> pc stays 0x2000. Release with pcsrc=0 -> 0x2004.
- pc=0x3000, exc=1 with stall=1 -> pc=EXC_VEC, epc=0x3000, cause=1, in_exc=1. A second exc is ignored. eret -> pc=0x3000, in_exc=0.
- jr=1, rs_val=0x5002 -> pc=EXC_VEC, cause=2. jr with rs_val=0x5004 and in_exc=0 -> pc=0x5004.
- PC_RAS_EN, RAS_DEPTH=4: 5 JAL pushes, then 5 jr with matching rs_val -> 4 hits, then ras_miss=1 on the 5th pop.
